// File: rtl/norm_shift_pipe.sv
// Normalising left shifter for the FP adder: leading-zero (exponent-clamped) or external shift, truncate, sticky.
// Latency: 2 register stages (R1 = operand + shift amount, R2 = result); one result per cycle sustained.
// Backpressure: full valid/ready; each stage advances when the stage after it is empty or draining.
module norm_shift_pipe #(
  parameter  int WIDTH     = 27,
  parameter  int WIDTH_OUT = 24,
  parameter  int EXP_W     = 8,
  localparam int SW        = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     m,
  input  logic [EXP_W-1:0]     e,
  input  logic                 ext,
  input  logic [SW-1:0]        sh_ext,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] out,
  output logic [EXP_W-1:0]     e_out,
  output logic                 sticky,
  output logic                 zero,
  output logic                 uf
);

  // Common width for comparing the leading-zero count against the exponent.
  localparam int CW = (SW > EXP_W) ? SW : EXP_W;

  // Stage 1 (operand + shift amount) registers.
  logic             r1_vld;
  logic [WIDTH-1:0] r1_m;
  logic [SW-1:0]    r1_amt;
  logic [EXP_W-1:0] r1_e;
  logic             r1_uf;
  logic             r1_zero;

  // Stage 2 (result) registers.
  logic                 r2_vld;
  logic [WIDTH_OUT-1:0] r2_out;
  logic [EXP_W-1:0]     r2_e;
  logic                 r2_sticky;
  logic                 r2_zero;
  logic                 r2_uf;

  logic             w_adv1;
  logic             w_adv2;
  logic [SW-1:0]    w_lz;
  logic [SW-1:0]    w_amt;
  logic [EXP_W-1:0] w_e_out;
  logic             w_uf;
  logic             w_zero;

  logic [WIDTH-1:0]     w_d;
  logic [WIDTH_OUT-1:0] w_out;
  logic                 w_sticky;

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_adv2   = !r2_vld || out_ready;
  assign w_adv1   = !r1_vld || w_adv2;
  assign in_ready = w_adv1;

  // Leading-zero count; the highest set bit wins, all-zero operand gives WIDTH.
  always_comb begin
    w_lz = SW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (m[i]) w_lz = SW'(WIDTH - 1 - i);
    end
  end

  // Shift amount and exponent: clamp normalisation so the exponent bottoms out at zero.
  always_comb begin
    w_zero  = (m == '0);
    w_uf    = 1'b0;
    w_amt   = w_lz;
    w_e_out = e;
    if (ext) begin
      w_amt = sh_ext;
    end else if (CW'(w_lz) > CW'(e)) begin
      w_amt   = SW'(e);
      w_uf    = 1'b1;
      w_e_out = '0;
    end else begin
      w_e_out = e - EXP_W'(w_lz);
    end
    // A zero mantissa carries no exponent and is never reported as denormal.
    if (w_zero) begin
      w_uf    = 1'b0;
      w_e_out = '0;
    end
  end

  // Shift, truncate to the output width and fold the discarded bits into sticky.
  always_comb begin
    w_d      = r1_m << r1_amt;
    w_out    = w_d[WIDTH-1 -: WIDTH_OUT];
    w_sticky = |w_d[WIDTH-WIDTH_OUT-1:0];
  end

  // Stage 1: capture operand and its shift amount whenever the stage can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_vld  <= 1'b0;
      r1_m    <= '0;
      r1_amt  <= '0;
      r1_e    <= '0;
      r1_uf   <= 1'b0;
      r1_zero <= 1'b0;
    end else if (w_adv1) begin
      r1_vld <= in_valid;
      if (in_valid) begin
        r1_m    <= m;
        r1_amt  <= w_amt;
        r1_e    <= w_e_out;
        r1_uf   <= w_uf;
        r1_zero <= w_zero;
      end
    end
  end

  // Stage 2: result register, held stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_vld    <= 1'b0;
      r2_out    <= '0;
      r2_e      <= '0;
      r2_sticky <= 1'b0;
      r2_zero   <= 1'b0;
      r2_uf     <= 1'b0;
    end else if (w_adv2) begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2_out    <= w_out;
        r2_e      <= r1_e;
        r2_sticky <= w_sticky;
        r2_zero   <= r1_zero;
        r2_uf     <= r1_uf;
      end
    end
  end

  assign out_valid = r2_vld;
  assign out       = r2_out;
  assign e_out     = r2_e;
  assign sticky    = r2_sticky;
  assign zero      = r2_zero;
  assign uf        = r2_uf;

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Bench for norm_shift_pipe: directed vectors, arithmetic reference model with an in-order queue,
// per-cycle output comparison, plus literal expectations for the test-plan vectors.
module tb_norm_shift_pipe;
  localparam int WIDTH     = 27;
  localparam int WIDTH_OUT = 24;
  localparam int EXP_W     = 8;
  localparam int SW        = $clog2(WIDTH + 1);

  typedef struct packed {
    logic [WIDTH_OUT-1:0] out;
    logic [EXP_W-1:0]     e_out;
    logic                 sticky;
    logic                 zero;
    logic                 uf;
  } res_t;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 in_valid  = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     m         = '0;
  logic [EXP_W-1:0]     e         = '0;
  logic                 ext       = 1'b0;
  logic [SW-1:0]        sh_ext    = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [WIDTH_OUT-1:0] out;
  logic [EXP_W-1:0]     e_out;
  logic                 sticky;
  logic                 zero;
  logic                 uf;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  res_t q[$];
  res_t mon_tmp;

  always #5 clk = ~clk;

  norm_shift_pipe #(.WIDTH(WIDTH), .WIDTH_OUT(WIDTH_OUT), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .m(m), .e(e), .ext(ext), .sh_ext(sh_ext),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .e_out(e_out),
    .sticky(sticky), .zero(zero), .uf(uf)
  );

  // Reference: search for the leading one, clamp by exponent, shift with wide integer arithmetic.
  function automatic res_t model(input logic [WIDTH-1:0] mm, input logic [EXP_W-1:0] ee,
                                 input logic x, input logic [SW-1:0] sh);
    res_t r;
    int lz;
    int amt;
    longint unsigned d;
    r = '0;
    if (mm == '0) begin
      r.zero = 1'b1;
      return r;
    end
    if (x) begin
      amt     = int'(sh);
      r.e_out = ee;
    end else begin
      lz = 0;
      while (mm[WIDTH-1-lz] == 1'b0) lz++;
      if (lz > int'(ee)) begin
        amt  = int'(ee);
        r.uf = 1'b1;
      end else begin
        amt     = lz;
        r.e_out = EXP_W'(int'(ee) - lz);
      end
    end
    if (amt >= WIDTH) d = 0;
    else d = (64'(mm) << amt) & ((64'd1 << WIDTH) - 64'd1);
    r.out    = WIDTH_OUT'(d >> (WIDTH - WIDTH_OUT));
    r.sticky = (d & ((64'd1 << (WIDTH - WIDTH_OUT)) - 64'd1)) != 0;
    return r;
  endfunction

  function automatic res_t mk(input logic [WIDTH_OUT-1:0] o, input logic [EXP_W-1:0] eo,
                              input logic s, input logic z, input logic u);
    res_t r;
    r.out = o; r.e_out = eo; r.sticky = s; r.zero = z; r.uf = u;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input res_t exp);
    check({tag, ".out"},    64'(out),    64'(exp.out));
    check({tag, ".e_out"},  64'(e_out),  64'(exp.e_out));
    check({tag, ".sticky"}, 64'(sticky), 64'(exp.sticky));
    check({tag, ".zero"},   64'(zero),   64'(exp.zero));
    check({tag, ".uf"},     64'(uf),     64'(exp.uf));
  endtask

  // Scoreboard: every valid output cycle must match the oldest outstanding accepted operand.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'(0));
        end else begin
          check_outs("stream", q[0]);
          if (out_ready) begin
            mon_tmp = q.pop_front();
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(m, e, ext, sh_ext));
    end else begin
      q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] mm, input logic [EXP_W-1:0] ee,
                       input logic x, input logic [SW-1:0] sh);
    in_valid = 1'b1; m = mm; e = ee; ext = x; sh_ext = sh;
  endtask

  // Single operand through an empty pipe with out_ready high; checks latency and literal result.
  task automatic run_one(input string tag, input logic [WIDTH-1:0] mm, input logic [EXP_W-1:0] ee,
                         input logic x, input logic [SW-1:0] sh, input res_t exp);
    check({tag, ".model"}, 64'(model(mm, ee, x, sh)), 64'(exp));
    drive(mm, ee, x, sh);
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".lat_early"}, 64'(out_valid), 64'(0));
    tick();
    @(negedge clk);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(1));
    check_outs(tag, exp);
    tick();
  endtask

  initial begin
    int n0;
    logic [WIDTH_OUT-1:0] held_out;
    logic [EXP_W-1:0]     held_e;

    // Reset state
    #2;
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check_outs("rst", mk('0, '0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'(1));
    tick();

    // Test-plan vectors and boundaries
    run_one("norm",     27'h1000001,   8'd10,  1'b0, 5'd0,  mk(24'h800000, 8'd8,   1'b1, 1'b0, 1'b0));
    run_one("ext3",     27'h7FFFFFF,   8'd20,  1'b1, 5'd3,  mk(24'hFFFFFF, 8'd20,  1'b0, 1'b0, 1'b0));
    run_one("clamp",    27'h0000100,   8'd5,   1'b0, 5'd0,  mk(24'h000400, 8'd0,   1'b0, 1'b0, 1'b1));
    run_one("zero",     27'h0000000,   8'd100, 1'b0, 5'd0,  mk(24'h000000, 8'd0,   1'b0, 1'b1, 1'b0));
    run_one("ext_all",  27'h7FFFFFF,   8'd3,   1'b1, 5'd27, mk(24'h000000, 8'd3,   1'b0, 1'b0, 1'b0));
    run_one("ext0",     27'h0000005,   8'd7,   1'b1, 5'd0,  mk(24'h000000, 8'd7,   1'b1, 1'b0, 1'b0));
    run_one("msb_e0",   27'h4000000,   8'd0,   1'b0, 5'd0,  mk(24'h800000, 8'd0,   1'b0, 1'b0, 1'b0));
    run_one("lsb_e200", 27'h0000001,   8'd200, 1'b0, 5'd0,  mk(24'h800000, 8'd174, 1'b0, 1'b0, 1'b0));
    run_one("zero_ext", 27'h0000000,   8'd9,   1'b1, 5'd2,  mk(24'h000000, 8'd0,   1'b0, 1'b1, 1'b0));

    // Throughput: 8 back-to-back operands, one result per cycle
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      drive(WIDTH'(27'h5A5A5A5 >> (3 * i)) | WIDTH'(i), EXP_W'(i * 7), i[0], SW'(i * 3));
      @(negedge clk);
      check("tput.in_ready", 64'(in_ready), 64'(1));
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk); #1;
    check("tput.count", 64'(n_out - n0), 64'(8));
    tick();

    // Backpressure: out_ready low for 4 cycles with 3 operands offered
    n0 = n_out;
    out_ready = 1'b0;
    drive(27'h0123456, 8'd30, 1'b0, 5'd0);
    @(negedge clk);
    check("bp.rdy_a", 64'(in_ready), 64'(1));
    tick();
    drive(27'h2000003, 8'd40, 1'b1, 5'd2);
    @(negedge clk);
    check("bp.rdy_b", 64'(in_ready), 64'(1));
    tick();
    drive(27'h0000F0F, 8'd3, 1'b0, 5'd0);
    @(negedge clk);
    check("bp.rdy_full", 64'(in_ready), 64'(0));
    check("bp.valid", 64'(out_valid), 64'(1));
    held_out = out;
    held_e   = e_out;
    tick();
    @(negedge clk);
    check("bp.rdy_full2", 64'(in_ready), 64'(0));
    check("bp.stable_out", 64'(out), 64'(held_out));
    check("bp.stable_e", 64'(e_out), 64'(held_e));
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.rdy_resume", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0 && !out_valid) break;
      tick();
    end
    check("bp.drain", 64'(q.size()), 64'(0));
    check("bp.count", 64'(n_out - n0), 64'(3));

    // Reset mid-stream with two items in flight
    out_ready = 1'b0;
    drive(27'h1000001, 8'd10, 1'b0, 5'd0);
    @(negedge clk);
    tick();
    drive(27'h7FFFFFF, 8'd20, 1'b1, 5'd3);
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    check("mid.pre_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid.out_valid", 64'(out_valid), 64'(0));
    check_outs("mid", mk('0, '0, 1'b0, 1'b0, 1'b0));
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("mid.no_stale", 64'(out_valid), 64'(0));
      tick();
    end
    run_one("post_rst", 27'h0000100, 8'd5, 1'b0, 5'd0, mk(24'h000400, 8'd0, 1'b0, 1'b0, 1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
